// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator and the draw stages.
// The generator drives it through the out modport; draw stages read it through in.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (default 800x600@60, 40 MHz pixel clock).
// The sync and blank strobes are registered from the next-state counters, so they line up with hcount/vcount.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    vga_if.out   out
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FRST = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_LAST = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FRST = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_LAST = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;

    always_comb begin
        hcnt_d = hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = 11'd0;
            vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
        end
    end

    // Strobes decode the counter values that will be visible next cycle.
    always_comb begin
        hblnk_d = (hcnt_d >= H_VIS);
        vblnk_d = (vcnt_d >= V_VIS);
        hsync_d = ((hcnt_d >= HS_FRST) && (hcnt_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vcnt_d >= VS_FRST) && (vcnt_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

    // rst is asserted asynchronously and expected to be released in step with clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q  <= 11'd0;
            vcnt_q  <= 11'd0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            hblnk_q <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            hblnk_q <= hblnk_d;
            vblnk_q <= vblnk_d;
        end
    end

    assign out.hcount = hcnt_q;
    assign out.vcount = vcnt_q;
    assign out.hsync  = hsync_q;
    assign out.vsync  = vsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vblnk  = vblnk_q;
    assign out.rgb    = 12'h000;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced raster (32x20 total) driven at both sync polarities side by side.
// Expected samples come from a cycle-index model, are queued at each clock and popped when sampled.
module tb_vga_timing_gen;
    localparam int HV = 16, HFP = 4, HSW = 8, HBP = 4;
    localparam int VV = 12, VFP = 1, VSW = 4, VBP = 3;
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } smp_t;

    typedef struct packed {
        smp_t a;
        smp_t b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    exp_t q[$];

    vga_if bus_a ();
    vga_if bus_b ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .out(bus_a));

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .out(bus_b));

    always #5 clk = ~clk;

    smp_t act_a, act_b;
    assign act_a = {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync,
                    bus_a.hblnk, bus_a.vblnk, bus_a.rgb};
    assign act_b = {bus_b.hcount, bus_b.vcount, bus_b.hsync, bus_b.vsync,
                    bus_b.hblnk, bus_b.vblnk, bus_b.rgb};

    function automatic smp_t model(int c, logic pol);
        smp_t s;
        int h, v;
        h     = c % HT;
        v     = (c / HT) % VT;
        s.h   = 11'(h);
        s.v   = 11'(v);
        s.hb  = (h >= HV);
        s.vb  = (v >= VV);
        s.hs  = (h >= HV + HFP && h < HV + HFP + HSW) ? pol : ~pol;
        s.vs  = (v >= VV + VFP && v < VV + VFP + VSW) ? pol : ~pol;
        s.rgb = 12'h000;
        return s;
    endfunction

    function automatic smp_t rst_val(logic pol);
        smp_t s;
        s     = '0;
        s.hs  = ~pol;
        s.vs  = ~pol;
        return s;
    endfunction

    function automatic exp_t expect_at(int c);
        exp_t e;
        e.a = model(c, 1'b1);
        e.b = model(c, 1'b0);
        return e;
    endfunction

    // One pixel clock: queue what the raster must show for the new cycle, then move to the sample point.
    task automatic advance();
        @(posedge clk);
        cyc++;
        q.push_back(expect_at(cyc));
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({act_a, act_b} !== {rst_val(1'b1), rst_val(1'b0)}) begin
            mismatched++;
            $display("FAIL reset_hold got a=%h b=%h want a=%h b=%h",
                     act_a, act_b, rst_val(1'b1), rst_val(1'b0));
        end
        rst = 1'b0;
        cyc = 0;
        q.push_back(expect_at(0));
        e = q.pop_front();
        compared++;
        if ({act_a, act_b} !== {e.a, e.b}) begin
            mismatched++;
            $display("FAIL reset_release got a=%h b=%h want a=%h b=%h", act_a, act_b, e.a, e.b);
        end
    endtask

    task automatic test_hblank_hsync();
        exp_t e;
        int   hs_cnt = 0;
        int   hs_first = -1;
        for (int i = 1; i < HT; i++) begin
            advance();
            e = q.pop_front();
            compared++;
            if ({act_a, act_b} !== {e.a, e.b}) begin
                mismatched++;
                $display("FAIL hline cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, act_a, act_b, e.a, e.b);
            end
            if (act_a.hs === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(act_a.h);
            end
        end
        compared++;
        if (hs_cnt !== HSW || hs_first !== HV + HFP) begin
            mismatched++;
            $display("FAIL hsync_window got width=%0d start=%0d want width=%0d start=%0d",
                     hs_cnt, hs_first, HSW, HV + HFP);
        end
    endtask

    task automatic test_line_wrap();
        exp_t e;
        int   guard = 0;
        while (!(cyc % HT == HT - 1 && (cyc / HT) % VT == 10) && guard < 4 * HT * VT) begin
            advance();
            guard++;
            e = q.pop_front();
            compared++;
            if ({act_a, act_b} !== {e.a, e.b}) begin
                mismatched++;
                $display("FAIL line_run cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, act_a, act_b, e.a, e.b);
            end
        end
        advance();
        e = q.pop_front();
        compared++;
        if (act_a.h !== 11'd0 || act_a.v !== 11'd11 || act_a.hb !== 1'b0 || {act_a, act_b} !== {e.a, e.b}) begin
            mismatched++;
            $display("FAIL line_wrap got a=%h b=%h want h=0 v=11 a=%h b=%h", act_a, act_b, e.a, e.b);
        end
    endtask

    task automatic test_vblank_vsync();
        exp_t e;
        int   vs_a = 0;
        int   vs_b = 0;
        int   guard = 0;
        while (!(cyc % HT == HT - 1 && (cyc / HT) % VT == VV - 1) && guard < 4 * HT * VT) begin
            advance();
            guard++;
            e = q.pop_front();
            compared++;
            if ({act_a, act_b} !== {e.a, e.b}) begin
                mismatched++;
                $display("FAIL pre_vblank cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, act_a, act_b, e.a, e.b);
            end
        end
        advance();
        e = q.pop_front();
        compared++;
        if (act_a.vb !== 1'b1 || act_a.h !== 11'd0 || act_a.v !== 11'(VV)) begin
            mismatched++;
            $display("FAIL vblank_rise got h=%0d v=%0d vb=%b want h=0 v=%0d vb=1",
                     act_a.h, act_a.v, act_a.vb, VV);
        end
        while (!(cyc % HT == HT - 1 && (cyc / HT) % VT == VT - 1) && guard < 8 * HT * VT) begin
            advance();
            guard++;
            e = q.pop_front();
            compared++;
            if ({act_a, act_b} !== {e.a, e.b}) begin
                mismatched++;
                $display("FAIL vblank_run cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, act_a, act_b, e.a, e.b);
            end
            if (act_a.vs === 1'b1) vs_a++;
            if (act_b.vs === 1'b0) vs_b++;
        end
        compared++;
        if (vs_a !== VSW * HT || vs_b !== VSW * HT) begin
            mismatched++;
            $display("FAIL vsync_cycles got a=%0d b=%0d want %0d", vs_a, vs_b, VSW * HT);
        end
    endtask

    task automatic test_frame_wrap();
        exp_t e;
        int   wraps = 0;
        int   last_wrap = -1;
        int   bad_len = 0;
        for (int i = 0; i < 3 * HT * VT; i++) begin
            advance();
            e = q.pop_front();
            compared++;
            if ({act_a, act_b} !== {e.a, e.b}) begin
                mismatched++;
                $display("FAIL frames cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, act_a, act_b, e.a, e.b);
            end
            if (act_a.h === 11'd0 && act_a.v === 11'd0) begin
                if (last_wrap >= 0 && cyc - last_wrap != HT * VT) bad_len++;
                last_wrap = cyc;
                wraps++;
            end
        end
        compared++;
        if (wraps !== 3 || bad_len !== 0) begin
            mismatched++;
            $display("FAIL frame_period got wraps=%0d bad_lengths=%0d want wraps=3 bad_lengths=0", wraps, bad_len);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   guard = 0;
        while (!(cyc % HT == 12 && (cyc / HT) % VT == 15) && guard < 4 * HT * VT) begin
            advance();
            guard++;
            e = q.pop_front();
            compared++;
            if ({act_a, act_b} !== {e.a, e.b}) begin
                mismatched++;
                $display("FAIL seek cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, act_a, act_b, e.a, e.b);
            end
        end
        // Assert between clock edges so only the asynchronous path can clear the outputs.
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({act_a, act_b} !== {rst_val(1'b1), rst_val(1'b0)}) begin
            mismatched++;
            $display("FAIL async_reset got a=%h b=%h want a=%h b=%h",
                     act_a, act_b, rst_val(1'b1), rst_val(1'b0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        q.delete();
        q.push_back(expect_at(0));
        e = q.pop_front();
        compared++;
        if ({act_a, act_b} !== {e.a, e.b}) begin
            mismatched++;
            $display("FAIL mid_release got a=%h b=%h want a=%h b=%h", act_a, act_b, e.a, e.b);
        end
        for (int i = 0; i < 2 * HT; i++) begin
            advance();
            e = q.pop_front();
            compared++;
            if ({act_a, act_b} !== {e.a, e.b}) begin
                mismatched++;
                $display("FAIL resume cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, act_a, act_b, e.a, e.b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hblank_hsync();
        test_line_wrap();
        test_vblank_vsync();
        test_frame_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
